// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg
// Shared types and constants for the RV32 decode stage: XLEN, data/address
// types, base opcodes, the ID/EX pipeline bundle and an rd-write decode helper.
// Build option: DECODE_WB_BYPASS_EN (used by decode_stage) selects writeback
// bypass instead of a writeback-hazard stall.
package decode_stage_pkg;

    localparam int XLEN = 32;

    typedef logic [XLEN-1:0] data_t;
    typedef logic [4:0]      reg_addr_t;
    typedef logic            enable_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef struct packed {
        logic      valid;
        data_t     pc;
        data_t     rs1_data;
        data_t     rs2_data;
        data_t     imm;
        reg_addr_t rd;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic      funct7b5;
        logic      mem_read;
        logic      reg_wen;
    } ex_bundle_t;

    function automatic logic writes_rd(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_OP};
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if
// IF/ID slot handshake between the fetch side (master) and decode (slave).
//   if_valid_i : slot holds a live instruction
//   if_pc_i    : PC of the slot instruction
//   if_inst_i  : raw 32-bit instruction
//   stall_o    : decode asks fetch to hold PC and IF/ID this cycle
interface decode_stage_if;
    import decode_stage_pkg::*;

    logic  if_valid_i;
    data_t if_pc_i;
    data_t if_inst_i;
    logic  stall_o;

    modport master (output if_valid_i, if_pc_i, if_inst_i, input  stall_o);
    modport slave  (input  if_valid_i, if_pc_i, if_inst_i, output stall_o);

endinterface

// File: rtl/decode_stage_imm_gen.sv
// imm_gen
// Combinational immediate extraction, sign-extended to XLEN by format.
//   inst_i : raw instruction
//   imm_o  : I/S/B/U/J immediate; 0 for opcodes without an immediate
module imm_gen
    import decode_stage_pkg::*;
(
    input  data_t inst_i,
    output data_t imm_o
);

    always_comb begin
        imm_o = '0;
        case (inst_i[6:0])
            OP_LOAD, OP_IMM, OP_JALR:
                imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
            OP_STORE:
                imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            OP_BRANCH:
                imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7],
                         inst_i[30:25], inst_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_o = {inst_i[31:12], 12'b0};
            OP_JAL:
                imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12],
                         inst_i[20], inst_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage
// RV32 instruction decode with load-use / writeback hazard detection and the
// ID/EX pipeline register.
//   clk, rst_n            : clock, async active-low reset
//   ifid (slave)          : IF/ID slot in, stall_o out
//   rs1_o, rs2_o          : register file read addresses (combinational)
//   rs1_data_i, rs2_data_i: register file read data
//   wb_wen_i/rd_i/data_i  : writeback port as seen by the register file
//   flush_i               : EX redirect, kills the ID instruction
//   ex_*                  : ID/EX pipeline register outputs
// Build option DECODE_WB_BYPASS_EN: forward wb_data_i to a matching source
// instead of stalling one cycle for the register-file write to land.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    decode_stage_if.slave ifid,
    output reg_addr_t     rs1_o,
    output reg_addr_t     rs2_o,
    input  data_t         rs1_data_i,
    input  data_t         rs2_data_i,
    input  enable_t       wb_wen_i,
    input  reg_addr_t     wb_rd_i,
    input  data_t         wb_data_i,
    input  logic          flush_i,
    output logic          ex_valid_o,
    output data_t         ex_pc_o,
    output data_t         ex_rs1_data_o,
    output data_t         ex_rs2_data_o,
    output data_t         ex_imm_o,
    output reg_addr_t     ex_rd_o,
    output logic [6:0]    ex_opcode_o,
    output logic [2:0]    ex_funct3_o,
    output logic          ex_funct7b5_o,
    output logic          ex_mem_read_o,
    output logic          ex_reg_wen_o
);

    ex_bundle_t ex_d, ex_q;
    data_t      imm;
    data_t      rs1_val, rs2_val;
    logic       load_use, wb_hit1, wb_hit2, wb_stall, stall_int, issue;
    logic [6:0] opcode;

    assign rs1_o  = ifid.if_inst_i[19:15];
    assign rs2_o  = ifid.if_inst_i[24:20];
    assign opcode = ifid.if_inst_i[6:0];

    imm_gen u_imm_gen (
        .inst_i (ifid.if_inst_i),
        .imm_o  (imm)
    );

    assign load_use = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                      ((ex_q.rd == rs1_o) || (ex_q.rd == rs2_o)) && ifid.if_valid_i;

    assign wb_hit1 = wb_wen_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs1_o);
    assign wb_hit2 = wb_wen_i && (wb_rd_i != 5'd0) && (wb_rd_i == rs2_o);

`ifdef DECODE_WB_BYPASS_EN
    assign rs1_val  = wb_hit1 ? wb_data_i : rs1_data_i;
    assign rs2_val  = wb_hit2 ? wb_data_i : rs2_data_i;
    assign wb_stall = 1'b0;
`else
    // The retry after a writeback stall reads the freshly written register
    // file, so the same match must not stall a second time.
    logic  wb_retry_d, wb_retry_q;
    logic  wb_data_unused;

    assign wb_data_unused = ^wb_data_i;
    assign rs1_val  = rs1_data_i;
    assign rs2_val  = rs2_data_i;
    assign wb_stall = (wb_hit1 || wb_hit2) && ifid.if_valid_i && !wb_retry_q;

    always_comb begin
        wb_retry_d = wb_stall && !flush_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wb_retry_q <= 1'b0;
        else        wb_retry_q <= wb_retry_d;
    end
`endif

    assign stall_int    = !flush_i && (load_use || wb_stall);
    // Gated by rst_n so the stall request is quiet during reset regardless of inputs.
    assign ifid.stall_o = stall_int && rst_n;
    assign issue        = ifid.if_valid_i && !flush_i && !stall_int;

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = issue;
        ex_d.pc       = ifid.if_pc_i;
        ex_d.rs1_data = rs1_val;
        ex_d.rs2_data = rs2_val;
        ex_d.imm      = imm;
        ex_d.rd       = ifid.if_inst_i[11:7];
        ex_d.opcode   = opcode;
        ex_d.funct3   = ifid.if_inst_i[14:12];
        ex_d.funct7b5 = ifid.if_inst_i[30];
        ex_d.mem_read = issue && (opcode == OP_LOAD);
        ex_d.reg_wen  = issue && writes_rd(opcode);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ex_q <= '0;
        else        ex_q <= ex_d;
    end

    assign ex_valid_o    = ex_q.valid;
    assign ex_pc_o       = ex_q.pc;
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;
    assign ex_imm_o      = ex_q.imm;
    assign ex_rd_o       = ex_q.rd;
    assign ex_opcode_o   = ex_q.opcode;
    assign ex_funct3_o   = ex_q.funct3;
    assign ex_funct7b5_o = ex_q.funct7b5;
    assign ex_mem_read_o = ex_q.mem_read;
    assign ex_reg_wen_o  = ex_q.reg_wen;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    reg_addr_t  rs1_o, rs2_o;
    data_t      rs1_data_i, rs2_data_i;
    enable_t    wb_wen_i;
    reg_addr_t  wb_rd_i;
    data_t      wb_data_i;
    logic       flush_i;
    logic       ex_valid_o, ex_funct7b5_o, ex_mem_read_o, ex_reg_wen_o;
    data_t      ex_pc_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
    reg_addr_t  ex_rd_o;
    logic [6:0] ex_opcode_o;
    logic [2:0] ex_funct3_o;

    data_t regs [32];
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        valid;
        logic        mem_read;
        logic        reg_wen;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        chk_data;
    } exp_t;
    exp_t sbq[$];
    exp_t e;

    decode_stage_if ifid ();

    decode_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifid          (ifid),
        .rs1_o         (rs1_o),
        .rs2_o         (rs2_o),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .wb_wen_i      (wb_wen_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i),
        .ex_valid_o    (ex_valid_o),
        .ex_pc_o       (ex_pc_o),
        .ex_rs1_data_o (ex_rs1_data_o),
        .ex_rs2_data_o (ex_rs2_data_o),
        .ex_imm_o      (ex_imm_o),
        .ex_rd_o       (ex_rd_o),
        .ex_opcode_o   (ex_opcode_o),
        .ex_funct3_o   (ex_funct3_o),
        .ex_funct7b5_o (ex_funct7b5_o),
        .ex_mem_read_o (ex_mem_read_o),
        .ex_reg_wen_o  (ex_reg_wen_o)
    );

    always #5 clk = ~clk;

    // Register file model: x0 reads zero.
    assign rs1_data_i = (rs1_o == 5'd0) ? 32'h0 : regs[rs1_o];
    assign rs2_data_i = (rs2_o == 5'd0) ? 32'h0 : regs[rs2_o];

    localparam logic [31:0] I_ADDI_M1 = 32'hFFF00293; // addi x5,x0,-1
    localparam logic [31:0] I_LW      = 32'h0000A303; // lw x6,0(x1)
    localparam logic [31:0] I_ADD     = 32'h002303B3; // add x7,x6,x2
    localparam logic [31:0] I_ADDI_X3 = 32'h00118413; // addi x8,x3,1
    localparam logic [31:0] I_ADDI_X0 = 32'h00500493; // addi x9,x0,5

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        ifid.if_valid_i = v;
        ifid.if_pc_i    = pc;
        ifid.if_inst_i  = inst;
    endtask

    task automatic push(input logic v, input logic mr, input logic wen, input logic [4:0] rd,
                        input logic [31:0] imm, input logic [31:0] r1, input logic [31:0] r2,
                        input logic cd);
        exp_t x;
        x.valid = v; x.mem_read = mr; x.reg_wen = wen; x.rd = rd;
        x.imm = imm; x.rs1 = r1; x.rs2 = r2; x.chk_data = cd;
        sbq.push_back(x);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush_i = 1'b0;
        wb_wen_i = 1'b1; wb_rd_i = 5'd1; wb_data_i = 32'h1234_5678;
        drive(1'b1, 32'h40, I_LW);
        #2;
        checks++;
        if (ex_valid_o !== 1'b0 || ex_imm_o !== 32'h0 || ex_rd_o !== 5'd0 || ex_pc_o !== 32'h0) begin
            failures++;
            $display("FAIL reset_ex: valid=%b imm=%h rd=%0d pc=%h required all 0", ex_valid_o, ex_imm_o, ex_rd_o, ex_pc_o);
        end
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_stall: got %b want 0", ifid.stall_o);
        end
        tick();
        checks++;
        if (ex_valid_o !== 1'b0 || ex_mem_read_o !== 1'b0 || ex_reg_wen_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_clocked: valid=%b mr=%b wen=%b want 0", ex_valid_o, ex_mem_read_o, ex_reg_wen_o);
        end
        wb_wen_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
        drive(1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_addi();
        drive(1'b1, 32'h100, I_ADDI_M1);
        #1;
        checks++;
        if (rs1_o !== 5'd0 || rs2_o !== 5'd31) begin
            failures++;
            $display("FAIL addi_rsaddr: rs1=%0d rs2=%0d want 0 31", rs1_o, rs2_o);
        end
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL addi_stall: got %b want 0", ifid.stall_o);
        end
        push(1'b1, 1'b0, 1'b1, 5'd5, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b0);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_imm_o !== e.imm || ex_rd_o !== e.rd ||
            ex_reg_wen_o !== e.reg_wen || ex_mem_read_o !== e.mem_read) begin
            failures++;
            $display("FAIL addi_ex: v=%b imm=%h rd=%0d wen=%b mr=%b want v=%b imm=%h rd=%0d wen=%b mr=%b",
                     ex_valid_o, ex_imm_o, ex_rd_o, ex_reg_wen_o, ex_mem_read_o,
                     e.valid, e.imm, e.rd, e.reg_wen, e.mem_read);
        end
        checks++;
        if (ex_pc_o !== 32'h100 || ex_opcode_o !== 7'h13 || ex_funct3_o !== 3'd0) begin
            failures++;
            $display("FAIL addi_fields: pc=%h op=%h f3=%0d want 100 13 0", ex_pc_o, ex_opcode_o, ex_funct3_o);
        end
    endtask

    task automatic test_imm_formats();
        logic [31:0] insts [9] = '{32'hFE20AE23, 32'hFE208CE3, 32'h12345537, 32'h001000EF,
                                   32'hFFFFF197, 32'hFFF280E7, 32'hFFFFFFFF, 32'h12345537,
                                   32'h40000033};
        logic [31:0] imms  [9] = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'h00000800,
                                   32'hFFFFF000, 32'hFFFFFFFF, 32'h0, 32'h12345000, 32'h0};
        logic        wens  [9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        vals  [9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [4:0]  rds   [9] = '{5'd28, 5'd25, 5'd10, 5'd1, 5'd3, 5'd1, 5'd31, 5'd10, 5'd0};
        for (int i = 0; i < 9; i++) begin
            drive(vals[i], 32'h200 + 32'(i * 4), insts[i]);
            #1;
            checks++;
            if (ifid.stall_o !== 1'b0) begin
                failures++;
                $display("FAIL imm_stall[%0d]: got %b want 0", i, ifid.stall_o);
            end
            push(vals[i], 1'b0, wens[i], rds[i], imms[i], 32'h0, 32'h0, 1'b0);
            tick();
            e = sbq.pop_front();
            checks++;
            if (ex_valid_o !== e.valid || ex_reg_wen_o !== e.reg_wen || ex_mem_read_o !== e.mem_read ||
                (e.valid && (ex_imm_o !== e.imm || ex_rd_o !== e.rd))) begin
                failures++;
                $display("FAIL imm_fmt[%0d]: v=%b wen=%b mr=%b imm=%h rd=%0d want v=%b wen=%b mr=%b imm=%h rd=%0d",
                         i, ex_valid_o, ex_reg_wen_o, ex_mem_read_o, ex_imm_o, ex_rd_o,
                         e.valid, e.reg_wen, e.mem_read, e.imm, e.rd);
            end
        end
        checks++;
        if (ex_funct7b5_o !== 1'b1) begin
            failures++;
            $display("FAIL funct7b5: got %b want 1", ex_funct7b5_o);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_load_use();
        regs[6] = 32'h11;
        drive(1'b1, 32'h300, I_LW);
        #1;
        push(1'b1, 1'b1, 1'b1, 5'd6, 32'h0, 32'h100, 32'h0, 1'b0);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_mem_read_o !== e.mem_read || ex_rd_o !== e.rd ||
            ex_rs1_data_o !== e.rs1) begin
            failures++;
            $display("FAIL lu_load: v=%b mr=%b rd=%0d rs1=%h want v=%b mr=%b rd=%0d rs1=%h",
                     ex_valid_o, ex_mem_read_o, ex_rd_o, ex_rs1_data_o, e.valid, e.mem_read, e.rd, e.rs1);
        end
        drive(1'b1, 32'h304, I_ADD);
        #1;
        checks++;
        if (ifid.stall_o !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall: got %b want 1", ifid.stall_o);
        end
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_mem_read_o !== e.mem_read || ex_reg_wen_o !== e.reg_wen) begin
            failures++;
            $display("FAIL lu_bubble: v=%b mr=%b wen=%b want 0 0 0", ex_valid_o, ex_mem_read_o, ex_reg_wen_o);
        end
        regs[6] = 32'h55;
        #1;
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL lu_one_bubble: stall got %b want 0", ifid.stall_o);
        end
        push(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h55, 32'h22, 1'b1);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_reg_wen_o !== e.reg_wen || ex_rd_o !== e.rd ||
            ex_rs1_data_o !== e.rs1 || ex_rs2_data_o !== e.rs2 || ex_pc_o !== 32'h304) begin
            failures++;
            $display("FAIL lu_issue: v=%b wen=%b rd=%0d rs1=%h rs2=%h pc=%h want v=1 wen=1 rd=7 rs1=%h rs2=%h pc=304",
                     ex_valid_o, ex_reg_wen_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, ex_pc_o, e.rs1, e.rs2);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h400, I_LW);
        tick();
        drive(1'b1, 32'h404, I_ADD);
        flush_i = 1'b1;
        #1;
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: got %b want 0", ifid.stall_o);
        end
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_mem_read_o !== e.mem_read || ex_reg_wen_o !== e.reg_wen) begin
            failures++;
            $display("FAIL flush_kill: v=%b mr=%b wen=%b want 0 0 0", ex_valid_o, ex_mem_read_o, ex_reg_wen_o);
        end
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_wb_hazard();
        regs[3] = 32'h33;
        wb_wen_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hDEADBEEF;
        drive(1'b1, 32'h500, I_ADDI_X3);
        #1;
`ifdef DECODE_WB_BYPASS_EN
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL wb_bypass_stall: got %b want 0", ifid.stall_o);
        end
        push(1'b1, 1'b0, 1'b1, 5'd8, 32'h1, 32'hDEADBEEF, 32'h100, 1'b1);
`else
        checks++;
        if (ifid.stall_o !== 1'b1) begin
            failures++;
            $display("FAIL wb_stall: got %b want 1", ifid.stall_o);
        end
        push(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_reg_wen_o !== e.reg_wen) begin
            failures++;
            $display("FAIL wb_bubble: v=%b wen=%b want 0 0", ex_valid_o, ex_reg_wen_o);
        end
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL wb_one_stall: got %b want 0", ifid.stall_o);
        end
        push(1'b1, 1'b0, 1'b1, 5'd8, 32'h1, 32'h33, 32'h100, 1'b1);
`endif
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_rd_o !== e.rd || ex_imm_o !== e.imm ||
            ex_rs1_data_o !== e.rs1 || ex_rs2_data_o !== e.rs2) begin
            failures++;
            $display("FAIL wb_issue: v=%b rd=%0d imm=%h rs1=%h rs2=%h want v=%b rd=%0d imm=%h rs1=%h rs2=%h",
                     ex_valid_o, ex_rd_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o,
                     e.valid, e.rd, e.imm, e.rs1, e.rs2);
        end
        wb_wen_i = 1'b0; wb_rd_i = 5'd0; wb_data_i = 32'h0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_wb_x0();
        wb_wen_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'hCAFEF00D;
        drive(1'b1, 32'h600, I_ADDI_X0);
        #1;
        checks++;
        if (ifid.stall_o !== 1'b0) begin
            failures++;
            $display("FAIL x0_stall: got %b want 0", ifid.stall_o);
        end
        push(1'b1, 1'b0, 1'b1, 5'd9, 32'h5, 32'h0, 32'h5, 1'b1);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_rd_o !== e.rd || ex_imm_o !== e.imm ||
            ex_rs1_data_o !== e.rs1 || ex_rs2_data_o !== e.rs2) begin
            failures++;
            $display("FAIL x0_issue: v=%b rd=%0d imm=%h rs1=%h rs2=%h want 1 9 5 0 5",
                     ex_valid_o, ex_rd_o, ex_imm_o, ex_rs1_data_o, ex_rs2_data_o);
        end
        wb_wen_i = 1'b0; wb_data_i = 32'h0;
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    task automatic test_reset_mid_stall();
        regs[6] = 32'h77;
        drive(1'b1, 32'h700, I_LW);
        tick();
        drive(1'b1, 32'h704, I_ADD);
        #1;
        checks++;
        if (ifid.stall_o !== 1'b1) begin
            failures++;
            $display("FAIL rms_stall: got %b want 1", ifid.stall_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (ifid.stall_o !== 1'b0 || ex_valid_o !== 1'b0 || ex_mem_read_o !== 1'b0 ||
            ex_rd_o !== 5'd0 || ex_imm_o !== 32'h0 || ex_rs1_data_o !== 32'h0 || ex_pc_o !== 32'h0) begin
            failures++;
            $display("FAIL rms_async: stall=%b v=%b mr=%b rd=%0d imm=%h rs1=%h pc=%h want all 0",
                     ifid.stall_o, ex_valid_o, ex_mem_read_o, ex_rd_o, ex_imm_o, ex_rs1_data_o, ex_pc_o);
        end
        #2;
        rst_n = 1'b1;
        push(1'b1, 1'b0, 1'b1, 5'd7, 32'h0, 32'h77, 32'h22, 1'b1);
        tick();
        e = sbq.pop_front();
        checks++;
        if (ex_valid_o !== e.valid || ex_reg_wen_o !== e.reg_wen || ex_rd_o !== e.rd ||
            ex_rs1_data_o !== e.rs1 || ex_rs2_data_o !== e.rs2) begin
            failures++;
            $display("FAIL rms_issue: v=%b wen=%b rd=%0d rs1=%h rs2=%h want 1 1 7 %h %h",
                     ex_valid_o, ex_reg_wen_o, ex_rd_o, ex_rs1_data_o, ex_rs2_data_o, e.rs1, e.rs2);
        end
        drive(1'b0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) regs[r] = 32'h0;
        regs[1] = 32'h100;
        regs[2] = 32'h22;
        regs[5] = 32'h5;
        test_reset();
        test_addi();
        test_imm_formats();
        test_load_use();
        test_flush();
        test_wb_hazard();
        test_wb_x0();
        test_reset_mid_stall();
        checks++;
        if (sbq.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d left want 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
